// File: rtl/lm32_itlb_walker_if.sv
// Wishbone read-only master bundle used by the ITLB page-table walker.
// The walker drives address/cycle/strobe; the bus returns data/ack/err.
interface lm32_itlb_walker_if;
    logic [31:0] wb_adr_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;

    modport master (
        output wb_adr_o, wb_cyc_o, wb_stb_o,
        input  wb_dat_i, wb_ack_i, wb_err_i
    );

    modport slave (
        input  wb_adr_o, wb_cyc_o, wb_stb_o,
        output wb_dat_i, wb_ack_i, wb_err_i
    );
endinterface

// File: rtl/lm32_itlb_walker.sv
// ITLB hardware refill engine: single-level linear page-table walker.
// Optional bus timeout enabled by defining CFG_ITLB_WALKER_TIMEOUT_EN.
module lm32_itlb_walker #(
    parameter int unsigned page_size     = 4096,
    parameter int unsigned pte_valid_bit = 0,
    parameter int unsigned pte_exec_bit  = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        miss_i,
    input  logic [29:0] miss_addr_i,
    input  logic [31:0] ptbr_i,
    input  logic        walk_en_i,
    input  logic        abort_i,
    lm32_itlb_walker_if.master wb,
    output logic        refill_o,
    output logic [31:0] refill_vaddr_o,
    output logic [31:0] refill_paddr_o,
    output logic        fault_o,
    output logic [31:0] fault_addr_o,
    output logic        busy_o
);

    localparam int unsigned OFF = $clog2(page_size);
    localparam logic [31:0] PG_MASK = ~(32'(page_size) - 32'd1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BUS,
        S_CHECK,
        S_REFILL,
        S_FAULT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] vaddr_q, vaddr_d;
    logic [31:0] pte_q, pte_d;
    logic [31:0] fault_addr_q, fault_addr_d;
    logic        abort_pend_q, abort_pend_d;
    logic        rearm_q, rearm_d;
    logic        pend;
    logic        tmo_hit;
    logic [31:0] pte_addr;

`ifdef CFG_ITLB_WALKER_TIMEOUT_EN
    logic [11:0] tmo_q, tmo_d;
    assign tmo_hit = (tmo_q == 12'hfff);
`else
    assign tmo_hit = 1'b0;
`endif

    assign pte_addr = ptbr_i + ((vaddr_q >> OFF) << 2);
    assign pend     = abort_pend_q | abort_i;

    // Walk state register and datapath flops.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= S_IDLE;
            vaddr_q      <= '0;
            pte_q        <= '0;
            fault_addr_q <= '0;
            abort_pend_q <= 1'b0;
            rearm_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            vaddr_q      <= vaddr_d;
            pte_q        <= pte_d;
            fault_addr_q <= fault_addr_d;
            abort_pend_q <= abort_pend_d;
            rearm_q      <= rearm_d;
        end
    end

`ifdef CFG_ITLB_WALKER_TIMEOUT_EN
    // Bus wait counter, only present when the timeout is built in.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    // Next-state logic; a stale miss strobe must drop before re-walking.
    always_comb begin
        state_d      = state_q;
        vaddr_d      = vaddr_q;
        pte_d        = pte_q;
        fault_addr_d = fault_addr_q;
        abort_pend_d = abort_pend_q;
        rearm_d      = rearm_q;
`ifdef CFG_ITLB_WALKER_TIMEOUT_EN
        tmo_d        = tmo_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (rearm_q && !miss_i) begin
                    rearm_d = 1'b0;
                end
                if (miss_i && walk_en_i && !abort_i && !rearm_q) begin
                    vaddr_d      = {miss_addr_i, 2'b00};
                    abort_pend_d = 1'b0;
                    state_d      = S_BUS;
`ifdef CFG_ITLB_WALKER_TIMEOUT_EN
                    tmo_d        = '0;
`endif
                end
            end
            S_BUS: begin
                abort_pend_d = pend;
`ifdef CFG_ITLB_WALKER_TIMEOUT_EN
                tmo_d        = tmo_q + 12'd1;
`endif
                if (wb.wb_err_i || (tmo_hit && !wb.wb_ack_i)) begin
                    if (pend) begin
                        state_d = S_IDLE;
                    end else begin
                        fault_addr_d = vaddr_q;
                        state_d      = S_FAULT;
                    end
                end else if (wb.wb_ack_i) begin
                    pte_d   = wb.wb_dat_i;
                    state_d = pend ? S_IDLE : S_CHECK;
                end
            end
            S_CHECK: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (pte_q[pte_valid_bit] && pte_q[pte_exec_bit]) begin
                    state_d = S_REFILL;
                end else begin
                    fault_addr_d = vaddr_q;
                    state_d      = S_FAULT;
                end
            end
            S_REFILL: begin
                rearm_d = 1'b1;
                state_d = S_IDLE;
            end
            S_FAULT: begin
                rearm_d = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decode straight from state so reset clears them at once.
    always_comb begin
        wb.wb_cyc_o    = (state_q == S_BUS);
        wb.wb_stb_o    = (state_q == S_BUS);
        wb.wb_adr_o    = (state_q == S_BUS) ? pte_addr : '0;
        refill_o       = (state_q == S_REFILL);
        refill_vaddr_o = refill_o ? (vaddr_q & PG_MASK) : '0;
        refill_paddr_o = refill_o ? (pte_q & PG_MASK) : '0;
        fault_o        = (state_q == S_FAULT);
        fault_addr_o   = fault_addr_q;
        busy_o         = (state_q != S_IDLE);
    end

endmodule

// File: tb/tb_lm32_itlb_walker.sv
// Randomized bench for lm32_itlb_walker against a transaction-level model.
// Outputs are sampled and inputs driven on the falling clock edge.
module tb_lm32_itlb_walker;

    localparam int unsigned PAGE = 4096;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        miss_i;
    logic [29:0] miss_addr_i;
    logic [31:0] ptbr_i;
    logic        walk_en_i;
    logic        abort_i;
    logic        refill_o;
    logic [31:0] refill_vaddr_o;
    logic [31:0] refill_paddr_o;
    logic        fault_o;
    logic [31:0] fault_addr_o;
    logic        busy_o;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] last_fault = '0;

    lm32_itlb_walker_if wb ();

    lm32_itlb_walker dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .miss_i         (miss_i),
        .miss_addr_i    (miss_addr_i),
        .ptbr_i         (ptbr_i),
        .walk_en_i      (walk_en_i),
        .abort_i        (abort_i),
        .wb             (wb),
        .refill_o       (refill_o),
        .refill_vaddr_o (refill_vaddr_o),
        .refill_paddr_o (refill_paddr_o),
        .fault_o        (fault_o),
        .fault_addr_o   (fault_addr_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_pte_addr(input logic [31:0] pb,
                                               input logic [29:0] ma);
        logic [31:0] va;
        va = {ma, 2'b00};
        return pb + (va / PAGE) * 4;
    endfunction

    function automatic logic [31:0] m_page(input logic [31:0] a);
        return a - (a % PAGE);
    endfunction

    // One walk: kind 0 = none, 1 = refill, 2 = fault.
    task automatic run_walk(input logic [29:0] ma, input logic [31:0] pb,
                            input logic [31:0] pte, input int wt,
                            input bit err, input bit ack_too,
                            input int abort_at, input bit abort_chk);
        int exp_kind, exp_idx;
        int nref, nflt, ridx, fidx;
        logic [31:0] rv, rp, fa;
        bit held, rewalk, aborted;
        aborted = (abort_at >= 0) || (abort_chk && !err);
        if (abort_at >= 0) exp_kind = 0;
        else if (err) exp_kind = 2;
        else if (abort_chk) exp_kind = 0;
        else if (pte[0] && pte[1]) exp_kind = 1;
        else exp_kind = 2;
        exp_idx = err ? 0 : 1;

        miss_i  = 1'b0;
        abort_i = 1'b0;
        @(negedge clk_i);
        miss_addr_i = ma;
        ptbr_i      = pb;
        miss_i      = 1'b1;
        walk_en_i   = 1'b1;
        @(negedge clk_i);
        chk("bus_cyc", {31'd0, wb.wb_cyc_o}, 32'd1);
        chk("bus_adr", wb.wb_adr_o, m_pte_addr(pb, ma));
        chk("busy", {31'd0, busy_o}, 32'd1);
        walk_en_i   = 1'($urandom % 2);
        miss_addr_i = 30'($urandom);
        held = 1'b1;
        for (int i = 0; i < wt; i++) begin
            abort_i = (i == abort_at);
            @(negedge clk_i);
            abort_i = 1'b0;
            if (wb.wb_cyc_o !== 1'b1 || wb.wb_stb_o !== 1'b1) held = 1'b0;
        end
        chk("cyc_held", {31'd0, held}, 32'd1);
        wb.wb_ack_i = !err || ack_too;
        wb.wb_err_i = err;
        wb.wb_dat_i = pte;
        abort_i     = (abort_at == wt);
        @(negedge clk_i);
        wb.wb_ack_i = 1'b0;
        wb.wb_err_i = 1'b0;
        wb.wb_dat_i = $urandom;
        abort_i     = 1'b0;
        walk_en_i   = 1'b1;
        if (aborted) miss_i = 1'b0;
        chk("cyc_drop", {31'd0, wb.wb_cyc_o}, 32'd0);
        nref = 0; nflt = 0; ridx = -1; fidx = -1;
        rv = '0; rp = '0; fa = '0; rewalk = 1'b0;
        for (int k = 0; k < 5; k++) begin
            abort_i = (k == 0) && abort_chk && !err;
            if (refill_o) begin
                nref++; ridx = k; rv = refill_vaddr_o; rp = refill_paddr_o;
            end
            if (fault_o) begin
                nflt++; fidx = k; fa = fault_addr_o;
            end
            if (wb.wb_cyc_o) rewalk = 1'b1;
            @(negedge clk_i);
            abort_i = 1'b0;
        end
        chk("n_refill", nref, (exp_kind == 1) ? 1 : 0);
        chk("n_fault", nflt, (exp_kind == 2) ? 1 : 0);
        chk("no_rewalk", {31'd0, rewalk}, 32'd0);
        if (exp_kind == 1) begin
            chk("ref_lat", ridx, exp_idx);
            chk("ref_va", rv, m_page({ma, 2'b00}));
            chk("ref_pa", rp, m_page(pte));
        end
        if (exp_kind == 2) begin
            chk("flt_lat", fidx, exp_idx);
            chk("flt_addr", fa, {ma, 2'b00});
            last_fault = {ma, 2'b00};
        end
        chk("flt_hold", fault_addr_o, last_fault);
        chk("idle", {31'd0, busy_o}, 32'd0);
    endtask

    initial begin
        logic [31:0] pte, pb;
        int wt, ab, n;
        bit er, seen;
        rst_i = 1'b0;
        miss_i = 1'b0;
        miss_addr_i = '0;
        ptbr_i = '0;
        walk_en_i = 1'b0;
        abort_i = 1'b0;
        wb.wb_dat_i = '0;
        wb.wb_ack_i = 1'b0;
        wb.wb_err_i = 1'b0;
        #12;
        chk("rst_cyc", {31'd0, wb.wb_cyc_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_ref", {31'd0, refill_o}, 32'd0);
        chk("rst_flt", {31'd0, fault_o}, 32'd0);
        chk("rst_fa", fault_addr_o, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);

        run_walk(30'h00400401, 32'h00100000, 32'h12345003, 0, 0, 0, -1, 0);
        run_walk(30'h00400401, 32'h00100000, 32'h12345002, 0, 0, 0, -1, 0);
        run_walk(30'h00400401, 32'h00100000, 32'h12345001, 0, 0, 0, -1, 0);
        run_walk(30'h00400401, 32'h00100000, 32'h12345003, 0, 1, 1, -1, 0);
        run_walk(30'h00400401, 32'h00100000, 32'h12345003, 5, 0, 0, 0, 0);
        run_walk(30'h3fffffff, 32'hfffff000, 32'hfffff003, 2, 0, 0, -1, 0);
        run_walk(30'h00012345, 32'h00200000, 32'h00abc003, 1, 0, 0, -1, 1);

        for (int t = 0; t < 40; t++) begin
            wt = $urandom_range(0, 4);
            er = ($urandom % 5) == 0;
            ab = (($urandom % 5) == 0) ? $urandom_range(0, wt) : -1;
            pb = $urandom & ~(PAGE - 1);
            pte = $urandom;
            if (($urandom % 10) < 6) pte[1:0] = 2'b11;
            run_walk(30'($urandom), pb, pte, wt, er, 1'($urandom % 2), ab,
                     (ab < 0) && !er && (($urandom % 6) == 0));
        end

        miss_i = 1'b1;
        walk_en_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            if (wb.wb_cyc_o) seen = 1'b1;
        end
        chk("walk_dis", {31'd0, seen}, 32'd0);
        miss_i = 1'b0;
        @(negedge clk_i);

        miss_addr_i = 30'h00400401;
        ptbr_i = 32'h00100000;
        miss_i = 1'b1;
        walk_en_i = 1'b1;
        @(negedge clk_i);
        n = 0;
        seen = 1'b0;
        while (n < 5000 && !seen) begin
            @(negedge clk_i);
            n++;
            if (fault_o) seen = 1'b1;
        end
`ifdef CFG_ITLB_WALKER_TIMEOUT_EN
        chk("tmo_fault", {31'd0, seen}, 32'd1);
        chk("tmo_lat", {31'd0, (n >= 4095 && n <= 4097)}, 32'd1);
        chk("tmo_addr", fault_addr_o, 32'h01001004);
`else
        chk("no_tmo_flt", {31'd0, seen}, 32'd0);
        chk("no_tmo_cyc", {31'd0, wb.wb_cyc_o}, 32'd1);
`endif
        miss_i = 1'b0;
        wb.wb_ack_i = wb.wb_cyc_o;
        wb.wb_dat_i = 32'h0;
        @(negedge clk_i);
        wb.wb_ack_i = 1'b0;
        repeat (4) @(negedge clk_i);

        miss_i = 1'b1;
        @(negedge clk_i);
        chk("pre_rst_cyc", {31'd0, wb.wb_cyc_o}, 32'd1);
        #2 rst_i = 1'b0;
        #1;
        chk("mid_rst_cyc", {31'd0, wb.wb_cyc_o}, 32'd0);
        chk("mid_rst_stb", {31'd0, wb.wb_stb_o}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy_o}, 32'd0);
        chk("mid_rst_fa", fault_addr_o, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
